// File: rtl/param_bank.sv
// Double-buffered parameter register bank.
// Bytes from the UART input assembler land in a shadow bank. A packet whose
// every byte has been written is copied to the active bank on the next frame
// start, so downstream consumers never see a partially updated parameter set.
// Sticky error flags report out-of-range writes, inputs arriving while a
// packet is pending, and packets closed before every byte was written.
module param_bank #(
    parameter int NUM_WORDS  = 27,
    parameter int WORD_BYTES = 2,
    parameter int IDX_W      = 6
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              wr_en,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [7:0]                        wr_data,
    input  logic                              pkt_done,
    input  logic                              frame_start,
    output logic [NUM_WORDS*WORD_BYTES*8-1:0] active_flat,
    output logic                              pending,
    output logic                              commit,
    output logic                              err_range,
    output logic                              err_busy,
    output logic                              err_incomp
);

    localparam int NB = NUM_WORDS * WORD_BYTES;
    localparam int BW = NB * 8;
    localparam logic [IDX_W:0] NB_L = (IDX_W + 1)'(NB);

    // The byte index must be able to address every byte of the bank.
    generate
        if (NB > (1 << IDX_W)) begin : g_idx_too_narrow
            $error("param_bank: NUM_WORDS*WORD_BYTES exceeds 2**IDX_W");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [BW-1:0]   shadow_r;
    logic [BW-1:0]   active_r;
    logic [NB-1:0]   mask_r;
    logic            pending_r;
    logic            commit_r;
    logic            err_range_r;
    logic            err_busy_r;
    logic            err_incomp_r;

    logic            idx_in_range_s;
    logic            mask_full_s;
    logic            wr_ok_s;
    logic            range_hit_s;
    logic            busy_hit_s;
    logic            incomp_hit_s;
    logic            commit_s;

    assign idx_in_range_s = ({1'b0, wr_idx} < NB_L);
    assign mask_full_s    = &mask_r;

    // Next-state and per-cycle event decode; completeness is judged on the
    // mask as registered, so a byte written in the pkt_done cycle does not count.
    always_comb begin
        state_next_s = state_r;
        wr_ok_s      = 1'b0;
        range_hit_s  = 1'b0;
        busy_hit_s   = 1'b0;
        incomp_hit_s = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            ST_COLLECT: begin
                if (wr_en) begin
                    if (idx_in_range_s) begin
                        wr_ok_s = 1'b1;
                    end else begin
                        range_hit_s = 1'b1;
                    end
                end else begin
                    wr_ok_s = 1'b0;
                end
                if (pkt_done) begin
                    if (mask_full_s) begin
                        state_next_s = ST_PENDING;
                    end else begin
                        incomp_hit_s = 1'b1;
                    end
                end else begin
                    incomp_hit_s = 1'b0;
                end
            end
            ST_PENDING: begin
                if (wr_en || pkt_done) begin
                    busy_hit_s = 1'b1;
                end else begin
                    busy_hit_s = 1'b0;
                end
                if (frame_start) begin
                    commit_s     = 1'b1;
                    state_next_s = ST_COLLECT;
                end else begin
                    commit_s = 1'b0;
                end
            end
            default: begin
                state_next_s = ST_COLLECT;
            end
        endcase
    end

    // State, banks, coverage mask and flags; a busy set in the commit cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_COLLECT;
            shadow_r     <= {BW{1'b0}};
            active_r     <= {BW{1'b0}};
            mask_r       <= {NB{1'b0}};
            pending_r    <= 1'b0;
            commit_r     <= 1'b0;
            err_range_r  <= 1'b0;
            err_busy_r   <= 1'b0;
            err_incomp_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pending_r <= (state_next_s == ST_PENDING);
            commit_r  <= commit_s;

            if (commit_s) begin
                active_r <= shadow_r;
                mask_r   <= {NB{1'b0}};
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (wr_ok_s && (wr_idx == IDX_W'(b))) begin
                        shadow_r[b*8 +: 8] <= wr_data;
                        mask_r[b]          <= 1'b1;
                    end
                end
            end

            if (range_hit_s) begin
                err_range_r <= 1'b1;
            end else if (commit_s) begin
                err_range_r <= 1'b0;
            end

            if (busy_hit_s) begin
                err_busy_r <= 1'b1;
            end else if (commit_s) begin
                err_busy_r <= 1'b0;
            end

            if (incomp_hit_s) begin
                err_incomp_r <= 1'b1;
            end else if (commit_s) begin
                err_incomp_r <= 1'b0;
            end
        end
    end

    assign active_flat = active_r;
    assign pending     = pending_r;
    assign commit      = commit_r;
    assign err_range   = err_range_r;
    assign err_busy    = err_busy_r;
    assign err_incomp  = err_incomp_r;

endmodule

// File: tb/tb_param_bank.sv
// Testbench for param_bank: directed scenarios followed by random traffic.
// A byte-array reference model predicts every flag each cycle; each commit it
// predicts is queued and matched by a monitor when the DUT pulses commit.
module tb_param_bank;

    localparam int NW = 27;
    localparam int WB = 2;
    localparam int NB = NW * WB;
    localparam int W  = NB * 8;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [5:0]   wr_idx;
    logic [7:0]   wr_data;
    logic         pkt_done;
    logic         frame_start;
    logic [W-1:0] active_flat;
    logic         pending;
    logic         commit;
    logic         err_range;
    logic         err_busy;
    logic         err_incomp;

    param_bank #(.NUM_WORDS(NW), .WORD_BYTES(WB), .IDX_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_idx      (wr_idx),
        .wr_data     (wr_data),
        .pkt_done    (pkt_done),
        .frame_start (frame_start),
        .active_flat (active_flat),
        .pending     (pending),
        .commit      (commit),
        .err_range   (err_range),
        .err_busy    (err_busy),
        .err_incomp  (err_incomp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // reference model state
    logic [7:0]   sh_m [NB];
    logic [7:0]   act_m[NB];
    bit           msk_m[NB];
    bit           pend_m, cm_m, er_m, eb_m, ei_m;
    logic [W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic logic [W-1:0] pack_act();
        logic [W-1:0] v;
        for (int b = 0; b < NB; b++) v[b*8 +: 8] = act_m[b];
        return v;
    endfunction

    function automatic void model_reset();
        for (int b = 0; b < NB; b++) begin
            sh_m[b]  = 8'h00;
            act_m[b] = 8'h00;
            msk_m[b] = 1'b0;
        end
        pend_m = 1'b0; cm_m = 1'b0; er_m = 1'b0; eb_m = 1'b0; ei_m = 1'b0;
    endfunction

    // One clock edge worth of behaviour, straight from the rules of the block.
    function automatic void model_edge(input bit we, input int idx, input logic [7:0] d,
                                       input bit pd, input bit fs, input bit rn);
        bit full;
        if (!rn) begin
            model_reset();
            return;
        end
        cm_m = 1'b0;
        if (pend_m) begin
            if (fs) begin
                for (int b = 0; b < NB; b++) begin
                    act_m[b] = sh_m[b];
                    msk_m[b] = 1'b0;
                end
                exp_q.push_back(pack_act());
                cm_m = 1'b1; pend_m = 1'b0;
                er_m = 1'b0; eb_m = 1'b0; ei_m = 1'b0;
            end
            if (we || pd) eb_m = 1'b1;
        end else begin
            full = 1'b1;
            for (int b = 0; b < NB; b++) if (!msk_m[b]) full = 1'b0;
            if (we) begin
                if (idx < NB) begin
                    sh_m[idx]  = d;
                    msk_m[idx] = 1'b1;
                end else begin
                    er_m = 1'b1;
                end
            end
            if (pd) begin
                if (full) pend_m = 1'b1;
                else      ei_m = 1'b1;
            end
        end
    endfunction

    // Drive one cycle, advance the model, then compare the flags at the falling edge.
    task automatic step(input bit we, input int idx, input logic [7:0] d,
                        input bit pd, input bit fs, input bit rn);
        wr_en = we; wr_idx = 6'(idx); wr_data = d;
        pkt_done = pd; frame_start = fs; rst_n = rn;
        @(posedge clk);
        model_edge(we, idx, d, pd, fs, rn);
        @(negedge clk);
        chk("pending",     W'(pending),    W'(pend_m));
        chk("commit",      W'(commit),     W'(cm_m));
        chk("err_range",   W'(err_range),  W'(er_m));
        chk("err_busy",    W'(err_busy),   W'(eb_m));
        chk("err_incomp",  W'(err_incomp), W'(ei_m));
        chk("active_flat", active_flat,    pack_act());
    endtask

    task automatic idle();
        step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic wr(input int idx, input logic [7:0] d);
        step(1'b1, idx, d, 1'b0, 1'b0, 1'b1);
    endtask

    // Scoreboard monitor: every commit pulse must match the oldest predicted bank.
    always @(negedge clk) begin
        if (mon_en && commit === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_commit: got commit=1 required no commit");
            end else begin
                chk("commit_bank", active_flat, exp_q.pop_front());
            end
        end
    end

    initial begin
        wr_en = 1'b0; wr_idx = 6'd0; wr_data = 8'h00;
        pkt_done = 1'b0; frame_start = 1'b0; rst_n = 1'b0;
        model_reset();
        @(negedge clk);

        // reset held three cycles
        repeat (3) step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;

        // normal load, data = idx+1
        for (int i = 0; i < NB; i++) wr(i, 8'(i + 1));
        step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        idle();
        step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("word0",  W'(active_flat[15:0]),    W'(16'h0201));
        chk("word26", W'(active_flat[431:416]), W'(16'h3635));
        idle();

        // incomplete packet, then resend of the missing byte
        for (int i = 0; i < NB - 1; i++) wr(i, 8'(i) ^ 8'h5A);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        wr(NB - 1, 8'hC3);
        step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);

        // range error, then busy write while pending
        wr(60, 8'h77);
        for (int i = 0; i < NB; i++) wr(i, 8'(i + 1));
        step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        wr(0, 8'hFF);
        step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("word0_lo_kept", W'(active_flat[7:0]), W'(8'h01));

        // pkt_done with frame_start: no commit until the next frame_start,
        // which also carries a write that must raise err_busy
        for (int i = 0; i < NB; i++) wr(i, 8'(255 - i));
        step(1'b0, 0, 8'h00, 1'b1, 1'b1, 1'b1);
        idle();
        step(1'b1, 3, 8'h99, 1'b0, 1'b1, 1'b1);
        idle();

        // reset in the middle of a packet
        for (int i = 0; i <= 20; i++) wr(i, 8'hEE);
        step(1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NB; i++) wr(i, 8'(i * 3));
        step(1'b0, 0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 0, 8'h00, 1'b0, 1'b1, 1'b1);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)), 8'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 799) != 0);
        end
        repeat (3) idle();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL missing_commit: got %0d unmatched commits required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
